mostra_sequencia: RTL and testbench

- Presents the stored memory-game sequence to the player before each round: reads sequence memory positions 0..limite in order and lights each one-hot LED value for a fixed time, followed by a dark gap.
- It is the output end of the play/compare datapath: it shows the player what the comparison flow later expects them to enter.
- It sits beside the game control unit. That unit pulses `mostrar` and waits for `pronto` before entering the play-wait state.

---
 rtl/mostra_sequencia_pkg.sv | 28 ++
 rtl/mostra_sequencia_contador_tempo.sv | 36 +++
 rtl/mostra_sequencia.sv | 116 +++++++++++
 tb/tb_mostra_sequencia.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mostra_sequencia_pkg.sv
// Shared state codes for the sequence display block and its debug display.
package mostra_sequencia_pkg;

    // State encoding doubles as the debug code shown on db_estado.
    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        CARREGA = 4'h1,
        ACENDE  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hE;

    // Debug code for a state; any encoding outside the enum shows E.
    function automatic logic [3:0] codigo_db(input estado_t e);
        case (e)
            OCIOSO, CARREGA, ACENDE, APAGA, PROXIMO, FIM: codigo_db = e;
            default:                                      codigo_db = DB_ILEGAL;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        max2 = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mostra_sequencia_contador_tempo.sv
// Modulo-M phase timer: clears on zera, advances on conta, wraps after M-1.
module mostra_sequencia_contador_tempo #(
    parameter int M = 3,
    parameter int W = $clog2(M + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] valor,
    output logic         fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] valor_q, valor_d;

    // Next count: clear has priority over counting, wrap at M-1.
    always_comb begin
        valor_d = valor_q;
        if (zera)
            valor_d = '0;
        else if (conta)
            valor_d = (valor_q == ULTIMO) ? '0 : valor_q + 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) valor_q <= '0;
        else       valor_q <= valor_d;
    end

    assign valor = valor_q;
    assign fim   = (valor_q == ULTIMO);

endmodule

// File: rtl/mostra_sequencia.sv
// Shows memory positions 0..limite one at a time: each LED lit T_ON cycles,
// then T_OFF dark cycles, then pronto pulses for the game control unit.
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 3,
    parameter int T_OFF  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mostrar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ativo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int TM = max2(T_ON, T_OFF);
    localparam int TW = $clog2(TM + 1);
    localparam logic [TW-1:0] ON_ULT  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_ULT = TW'(T_OFF - 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [TW-1:0]     timer;
    logic              timer_fim;
    logic              zera, conta;
    logic              fim_on, fim_off;

    // One shared timer serves both phases; the longer phase can use its wrap flag.
    mostra_sequencia_contador_tempo #(.M(TM), .W(TW)) u_tempo (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .valor (timer),
        .fim   (timer_fim)
    );

    assign fim_on  = (T_ON  == TM) ? timer_fim : (timer == ON_ULT);
    assign fim_off = (T_OFF == TM) ? timer_fim : (timer == OFF_ULT);

    // Next-state, address/limit updates and timer control.
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        zera       = 1'b0;
        conta      = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (mostrar) estado_d = CARREGA;
            end
            CARREGA: begin
                endereco_d = '0;
                limite_d   = limite;
                zera       = 1'b1;
                estado_d   = ACENDE;
            end
            ACENDE: begin
                if (fim_on) begin
                    zera     = 1'b1;
                    estado_d = APAGA;
                end else begin
                    conta = 1'b1;
                end
            end
            APAGA: begin
                if (fim_off) begin
                    zera     = 1'b1;
                    // Ending by equality keeps the last position from wrapping to 0.
                    estado_d = (endereco_q == limite_q) ? FIM : PROXIMO;
                end else begin
                    conta = 1'b1;
                end
            end
            PROXIMO: begin
                endereco_d = endereco_q + 1'b1;
                estado_d   = ACENDE;
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                zera     = 1'b1;
                estado_d = OCIOSO;
            end
        endcase
    end

    // State, address and captured limit registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            limite_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
        end
    end

    assign endereco  = endereco_q;
    assign leds      = (estado_q == ACENDE) ? dado_mem : '0;
    assign ativo     = (estado_q != OCIOSO);
    assign pronto    = (estado_q == FIM);
    assign db_estado = codigo_db(estado_q);

endmodule

// File: tb/tb_mostra_sequencia.sv
// Bench for mostra_sequencia: per-cycle expected trace built from the
// show/gap/advance rules and compared against the DUT outputs.
module tb_mostra_sequencia;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] addr;
        logic       ativo;
        logic       pronto;
        logic [3:0] db;
    } obs_t;

    logic       clock, reset, mostrar;
    logic [3:0] limite, dado_mem, endereco, leds, db_estado;
    logic       ativo, pronto;
    logic [3:0] mem [16];

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    logic [3:0] last_addr;

    mostra_sequencia #(.ADDR_W(4), .DATA_W(4), .T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .mostrar   (mostrar),
        .limite    (limite),
        .dado_mem  (dado_mem),
        .endereco  (endereco),
        .leds      (leds),
        .ativo     (ativo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    assign dado_mem = mem[endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic obs_t mk(input logic [3:0] l, input logic [3:0] a,
                                input logic at, input logic p, input logic [3:0] d);
        obs_t o;
        o.leds = l; o.addr = a; o.ativo = at; o.pronto = p; o.db = d;
        return o;
    endfunction

    task automatic push_idle();
        exp_q.push_back(mk(4'h0, last_addr, 1'b0, 1'b0, 4'h0));
    endtask

    // Expected trace of one full presentation, from carrega through fim.
    task automatic push_run(input int L);
        exp_q.push_back(mk(4'h0, last_addr, 1'b1, 1'b0, 4'h1));
        for (int i = 0; i <= L; i++) begin
            repeat (T_ON)  exp_q.push_back(mk(mem[i], 4'(i), 1'b1, 1'b0, 4'h2));
            repeat (T_OFF) exp_q.push_back(mk(4'h0,   4'(i), 1'b1, 1'b0, 4'h3));
            if (i < L)     exp_q.push_back(mk(4'h0,   4'(i), 1'b1, 1'b0, 4'h4));
        end
        exp_q.push_back(mk(4'h0, 4'(L), 1'b1, 1'b1, 4'hF));
        last_addr = 4'(L);
    endtask

    // Consume the expected trace one cycle at a time, optionally poking
    // mostrar/limite or raising reset after the comparison of a given cycle.
    task automatic play_and_check(input string name, input int disturb_at, input int reset_at);
        int   idx = 0;
        obs_t e, got;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e   = exp_q.pop_front();
            got = {leds, endereco, ativo, pronto, db_estado};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cyc %0d got leds=%b end=%0d ativo=%b pronto=%b db=%h exp leds=%b end=%0d ativo=%b pronto=%b db=%h",
                         name, idx, got.leds, got.addr, got.ativo, got.pronto, got.db,
                         e.leds, e.addr, e.ativo, e.pronto, e.db);
            end
            if (idx == disturb_at) begin
                mostrar = 1'b1;
                limite  = 4'd3;
            end else if (disturb_at >= 0 && idx == disturb_at + 1) begin
                mostrar = 1'b0;
            end
            if (idx == reset_at) begin
                reset = 1'b1;
                exp_q.delete();
            end
            idx++;
        end
    endtask

    task automatic run_once(input string name, input int L, input int disturb_at, input int reset_at);
        push_idle();
        play_and_check({name, "_idle"}, -1, -1);
        limite  = 4'(L);
        mostrar = 1'b1;
        push_run(L);
        @(posedge clock);
        #1 mostrar = 1'b0;
        play_and_check(name, disturb_at, reset_at);
    endtask

    task automatic test_reset();
        reset = 1'b1; mostrar = 1'b0; limite = 4'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        last_addr = 4'd0;
        repeat (10) push_idle();
        play_and_check("reset_idle", -1, -1);
    endtask

    task automatic test_limite0();
        run_once("limite0", 0, -1, -1);
    endtask

    task automatic test_limite2();
        run_once("limite2", 2, -1, -1);
    endtask

    // mostrar pulse and a new limite during acende of position 0 must not matter.
    task automatic test_ignore();
        run_once("ignore", 2, 3, -1);
    endtask

    // Reset raised in the first gap cycle of position 1 (trace index 10).
    task automatic test_reset_mid();
        run_once("reset_mid", 2, -1, 10);
        @(posedge clock);
        #1 reset = 1'b0;
        last_addr = 4'd0;
        repeat (5) push_idle();
        play_and_check("after_reset", -1, -1);
    endtask

    task automatic test_back_to_back();
        push_idle();
        play_and_check("b2b_idle", -1, -1);
        limite  = 4'd1;
        mostrar = 1'b1;
        push_run(1); push_idle();
        push_run(1); push_idle();
        push_run(1);
        @(posedge clock);
        #1;
        play_and_check("b2b", -1, -1);
        mostrar = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int L;
            for (int k = 0; k < 16; k++) mem[k] = 4'b0001 << $urandom_range(0, 3);
            L = (r == 0) ? 15 : int'($urandom_range(0, 15));
            run_once("random", L, -1, -1);
        end
    endtask

    initial begin
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000; mem[3] = 4'b0010;
        for (int k = 4; k < 16; k++) mem[k] = 4'b0001;
        last_addr = 4'd0;
        test_reset();
        test_limite0();
        test_limite2();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
